spawn_requester: RTL and testbench

- Consumer side of the random-number generator: converts game spawn triggers (level start, bubble split/pop) into random ball spawn positions.
- Drives the generator's `rise` strobe with clean single-cycle pulses and samples the latched random word.
- Range-checks the word, retries or clamps it, then offers `spawn_x` / `spawn_dir` to the object manager over a valid/ready handshake.
- Sits between the game-control FSM and the random block, one instance per spawning object class.

---
 rtl/spawn_requester_if.sv | 24 ++
 rtl/spawn_requester.sv | 140 ++++++++++++++
 tb/tb_spawn_requester.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spawn_requester_if.sv
// Spawn offer channel between a spawn requester and the object manager.
// The master drives the offer; the slave returns ready.
interface spawn_requester_if #(
  parameter int SIZE_BITS = 10
);
  logic                 spawn_valid;
  logic                 spawn_ready;
  logic [SIZE_BITS-1:0] spawn_x;
  logic                 spawn_dir;

  modport master (
    output spawn_valid,
    output spawn_x,
    output spawn_dir,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_x,
    input  spawn_dir,
    output spawn_ready
  );
endinterface

// File: rtl/spawn_requester.sv
// Turns game spawn triggers into range-checked random spawn positions: pulses the
// generator's rise strobe, samples its word, retries or clamps, then offers it.
module spawn_requester #(
  parameter int SIZE_BITS   = 10,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 447,
  parameter int MAX_RETRY   = 3,
  parameter int MAX_PENDING = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [SIZE_BITS-1:0] rnd_in,
  output logic                 rise,
  spawn_requester_if.master    spawn,
  output logic [3:0]           pending,
  output logic                 clamped
);

  localparam logic [SIZE_BITS-1:0] X_LO      = SIZE_BITS'(X_MIN);
  localparam logic [SIZE_BITS-1:0] X_HI      = SIZE_BITS'(X_MAX);
  localparam logic [3:0]           RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [3:0]           PEND_SAT  = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    OFFER
  } state_t;

  state_t               r_state;
  logic [SIZE_BITS-1:0] r_sample;
  logic [SIZE_BITS-1:0] r_x;
  logic                 r_dir;
  logic                 r_valid;
  logic                 r_rise;
  logic                 r_clamped;
  logic [3:0]           r_pending;
  logic [3:0]           r_retry;

  logic                 w_xfer;
  logic                 w_below;
  logic                 w_above;
  logic [3:0]           w_pending_next;

  assign w_xfer  = r_valid && spawn.spawn_ready;
  assign w_below = r_sample < X_LO;
  assign w_above = r_sample > X_HI;

  // A trigger and a transfer in the same cycle cancel; saturation drops extra triggers.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_pending_next = r_pending;
    if (trigger && !w_xfer && (r_pending != PEND_SAT)) begin
      w_pending_next = r_pending + 4'd1;
    end else if (!trigger && w_xfer && (r_pending != 4'd0)) begin
      w_pending_next = r_pending - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sample  <= '0;
      r_x       <= '0;
      r_dir     <= 1'b0;
      r_valid   <= 1'b0;
      r_rise    <= 1'b0;
      r_clamped <= 1'b0;
      r_pending <= 4'd0;
      r_retry   <= 4'd0;
    end else begin
      r_pending <= w_pending_next;
      r_clamped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pending != 4'd0) begin
            r_state <= REQ;
            r_rise  <= 1'b1;
          end
        end
        REQ: begin
          r_state <= WAIT;
          r_rise  <= 1'b0;
        end
        WAIT: begin
          // The generator's output has settled one edge after the rise pulse.
          r_sample <= rnd_in;
          r_state  <= CHECK;
        end
        CHECK: begin
          if (!w_below && !w_above) begin
            r_x     <= r_sample;
            r_dir   <= r_sample[0];
            r_valid <= 1'b1;
            r_state <= OFFER;
          end else if (r_retry < RETRY_LIM) begin
            r_retry <= r_retry + 4'd1;
            r_rise  <= 1'b1;
            r_state <= REQ;
          end else begin
            r_x       <= w_below ? X_LO : X_HI;
            r_dir     <= r_sample[0];
            r_clamped <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= OFFER;
          end
        end
        OFFER: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_retry <= 4'd0;
            if (w_pending_next != 4'd0) begin
              r_rise  <= 1'b1;
              r_state <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_rise  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rise              = r_rise;
  assign spawn.spawn_valid = r_valid;
  assign spawn.spawn_x     = r_x;
  assign spawn.spawn_dir   = r_dir;
  assign pending           = r_pending;
  assign clamped           = r_clamped;

endmodule

// File: tb/tb_spawn_requester.sv
// Directed bench for spawn_requester: a table of sample sequences with expected
// spawn results, plus hand-written backlog, saturation and reset sequences.
module tb_spawn_requester;

  logic       clk;
  logic       reset;
  logic       trigger;
  logic [9:0] rnd_in;
  logic       rise;
  logic [3:0] pending;
  logic       clamped;

  spawn_requester_if #(.SIZE_BITS(10)) bus ();

  spawn_requester #(
    .SIZE_BITS  (10),
    .X_MIN      (32),
    .X_MAX      (447),
    .MAX_RETRY  (3),
    .MAX_PENDING(7)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trigger(trigger),
    .rnd_in (rnd_in),
    .rise   (rise),
    .spawn  (bus),
    .pending(pending),
    .clamped(clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stub generator: a word table consumed one entry per rise pulse,
  // presented on rnd_in just after the edge that ends the pulse.
  logic [9:0] stub_mem [32];
  int stub_wr = 0;
  int stub_rd = 0;

  initial begin
    rnd_in = '0;
    forever begin
      @(negedge clk);
      if (rise) begin
        @(posedge clk);
        #1;
        if (stub_rd < stub_wr) begin
          rnd_in = stub_mem[stub_rd % 32];
          stub_rd++;
        end else begin
          rnd_in = 10'd200;
        end
      end
    end
  end

  task automatic push_word(input int w);
    stub_mem[stub_wr % 32] = 10'(w);
    stub_wr++;
  endtask

  // Monitor: rise pulses, rise pulses closer than two low cycles, clamped pulses.
  int rise_cnt = 0;
  int gap_bad  = 0;
  int clamp_cnt = 0;
  int low_run  = 0;
  bit seen_rise = 1'b0;

  always @(negedge clk) begin
    if (rise) begin
      rise_cnt++;
      if (seen_rise && low_run < 2) gap_bad++;
      seen_rise = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (clamped) clamp_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int         n;
    logic [9:0] s [4];
    int         exp_x;
    int         exp_dir;
    int         exp_clamp;
  } vec_t;

  function automatic vec_t mk(input int n, input int a, input int b, input int c,
                              input int d, input int x, input int dir, input int cl);
    vec_t v;
    v.n = n;
    v.s[0] = 10'(a);
    v.s[1] = 10'(b);
    v.s[2] = 10'(c);
    v.s[3] = 10'(d);
    v.exp_x = x;
    v.exp_dir = dir;
    v.exp_clamp = cl;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int r0, c0, g0, lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    for (int i = 0; i < v.n; i++) push_word(int'(v.s[i]));
    r0 = rise_cnt;
    c0 = clamp_cnt;
    g0 = gap_bad;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check({tag, "_pending_after_trigger"}, int'(pending), 1);
    lat = 1;
    while (!bus.spawn_valid && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2 + 3 * v.n);
    check({tag, "_spawn_x"}, int'(bus.spawn_x), v.exp_x);
    check({tag, "_spawn_dir"}, int'(bus.spawn_dir), v.exp_dir);
    tick();
    check({tag, "_held_valid"}, int'(bus.spawn_valid), 1);
    check({tag, "_held_x"}, int'(bus.spawn_x), v.exp_x);
    check({tag, "_clamped_pulses"}, clamp_cnt - c0, v.exp_clamp);
    check({tag, "_rise_pulses"}, rise_cnt - r0, v.n);
    check({tag, "_rise_gap"}, gap_bad - g0, 0);
    bus.spawn_ready = 1'b1;
    tick();
    bus.spawn_ready = 1'b0;
    check({tag, "_valid_after_xfer"}, int'(bus.spawn_valid), 0);
    check({tag, "_pending_after_xfer"}, int'(pending), 0);
    repeat (3) tick();
  endtask

  vec_t tbl [8];

  initial begin
    int n, r0, got_x [8];
    bit x_moved;
    int first_x;

    tbl[0] = mk(1, 200, 0, 0, 0, 200, 0, 0);
    tbl[1] = mk(4, 10, 500, 460, 5, 32, 1, 1);
    tbl[2] = mk(4, 448, 448, 448, 1000, 447, 0, 1);
    tbl[3] = mk(1, 32, 0, 0, 0, 32, 0, 0);
    tbl[4] = mk(1, 447, 0, 0, 0, 447, 1, 0);
    tbl[5] = mk(3, 31, 448, 100, 0, 100, 0, 0);
    tbl[6] = mk(4, 0, 1023, 0, 33, 33, 1, 0);
    tbl[7] = mk(1, 301, 0, 0, 0, 301, 1, 0);

    reset = 1'b1;
    trigger = 1'b0;
    bus.spawn_ready = 1'b0;
    #3;
    check("reset_rise", int'(rise), 0);
    check("reset_valid", int'(bus.spawn_valid), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_clamped", int'(clamped), 0);
    check("reset_x", int'(bus.spawn_x), 0);
    check("reset_dir", int'(bus.spawn_dir), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_no_rise", rise_cnt, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Backlog: five triggers back to back with the consumer stalled.
    for (int i = 0; i < 5; i++) push_word(100 + i);
    trigger = 1'b1;
    repeat (5) tick();
    trigger = 1'b0;
    first_x = -1;
    x_moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.spawn_valid) begin
        if (first_x < 0) first_x = int'(bus.spawn_x);
        else if (int'(bus.spawn_x) != first_x) x_moved = 1'b1;
      end
      tick();
    end
    check("backlog_pending", int'(pending), 5);
    check("backlog_valid_held", int'(bus.spawn_valid), 1);
    check("backlog_x_first", first_x, 100);
    check("backlog_x_stable", int'(x_moved), 0);
    bus.spawn_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && (pending != 4'd0 || bus.spawn_valid); i++) begin
      if (bus.spawn_valid && n < 8) begin
        got_x[n] = int'(bus.spawn_x);
        n++;
      end
      tick();
    end
    bus.spawn_ready = 1'b0;
    check("backlog_transfers", n, 5);
    for (int i = 0; i < 5; i++) check($sformatf("backlog_order%0d", i), got_x[i], 100 + i);
    check("backlog_pending_end", int'(pending), 0);
    repeat (3) tick();

    // Saturation at MAX_PENDING, then a simultaneous trigger and transfer.
    for (int i = 0; i < 8; i++) push_word(200 + 2 * i);
    trigger = 1'b1;
    repeat (10) tick();
    trigger = 1'b0;
    check("sat_pending", int'(pending), 7);
    for (int i = 0; i < 40 && !bus.spawn_valid; i++) tick();
    check("sat_offer_valid", int'(bus.spawn_valid), 1);
    trigger = 1'b1;
    bus.spawn_ready = 1'b1;
    tick();
    trigger = 1'b0;
    check("sat_trig_and_xfer", int'(pending), 7);
    n = 0;
    for (int i = 0; i < 120 && (pending != 4'd0 || bus.spawn_valid); i++) begin
      if (bus.spawn_valid) n++;
      tick();
    end
    bus.spawn_ready = 1'b0;
    check("sat_drain_transfers", n, 7);
    check("sat_pending_end", int'(pending), 0);
    repeat (3) tick();

    // Reset while waiting for the generator's word.
    push_word(150);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 10 && !rise; i++) tick();
    check("rstwait_rise_seen", int'(rise), 1);
    tick();
    check("rstwait_pending_before", int'(pending), 1);
    reset = 1'b1;
    #1;
    check("rstwait_rise", int'(rise), 0);
    check("rstwait_valid", int'(bus.spawn_valid), 0);
    check("rstwait_pending", int'(pending), 0);
    tick();
    reset = 1'b0;
    r0 = rise_cnt;
    repeat (8) tick();
    check("rstwait_idle_rise", rise_cnt - r0, 0);
    check("rstwait_idle_valid", int'(bus.spawn_valid), 0);

    // Reset while an offer is outstanding.
    push_word(150);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 20 && !bus.spawn_valid; i++) tick();
    check("rstoffer_valid_before", int'(bus.spawn_valid), 1);
    reset = 1'b1;
    #1;
    check("rstoffer_valid", int'(bus.spawn_valid), 0);
    check("rstoffer_rise", int'(rise), 0);
    check("rstoffer_pending", int'(pending), 0);
    tick();
    reset = 1'b0;
    r0 = rise_cnt;
    repeat (8) tick();
    check("rstoffer_idle_rise", rise_cnt - r0, 0);
    check("rstoffer_idle_valid", int'(bus.spawn_valid), 0);

    run_vec(tbl[7], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
